// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over a
// fixed window of GATE_CYCLES clocks and reports the count once per window.
module freq_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] freq_out,
    output logic             freq_valid,
    output logic             overflow
);

    localparam int               GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   edge_s;
    logic [GW-1:0]          gate_cnt_r;
    logic [CNT_W-1:0]       edge_cnt_r;
    logic                   sat_r;

    // Synchronizer chain followed by the previous-value flop for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign edge_s = sync_r[SYNC_STAGES-1] & ~prev_r;

    // Measurement FSM with gate/edge counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            gate_cnt_r <= {GW{1'b0}};
            edge_cnt_r <= {CNT_W{1'b0}};
            sat_r      <= 1'b0;
            busy       <= 1'b0;
            freq_out   <= {CNT_W{1'b0}};
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r    <= GATE;
                        gate_cnt_r <= {GW{1'b0}};
                        edge_cnt_r <= {CNT_W{1'b0}};
                        sat_r      <= 1'b0;
                        busy       <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GATE: begin
                    // Saturate rather than wrap; remember that we tried to go past max
                    if (edge_s) begin
                        if (edge_cnt_r == CNT_MAX) begin
                            sat_r <= 1'b1;
                        end else begin
                            edge_cnt_r <= edge_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    if (gate_cnt_r == GATE_LAST) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                    end else begin
                        gate_cnt_r <= gate_cnt_r + {{(GW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    freq_out   <= edge_cnt_r;
                    overflow   <= sat_r;
                    freq_valid <= 1'b1;
                    state_r    <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with a 100-cycle gate: a 32-bit instance and a
// 4-bit instance share sig_in, each with its own start.
module tb_freq_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig_in;
    logic        start;
    logic        start4;
    logic        busy, freq_valid, overflow;
    logic [31:0] freq_out;
    logic        busy4, freq_valid4, overflow4;
    logic [3:0]  freq_out4;

    int n_tests = 0;
    int n_fail  = 0;
    int period  = 0;

    freq_meter #(.GATE_CYCLES(100), .CNT_W(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start),
        .busy(busy), .freq_out(freq_out), .freq_valid(freq_valid), .overflow(overflow)
    );

    freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start4),
        .busy(busy4), .freq_out(freq_out4), .freq_valid(freq_valid4), .overflow(overflow4)
    );

    always #10 clk = ~clk;

    // Square-wave source: toggles every period/2 clocks, held low when period is 0
    initial begin
        int ph;
        ph     = 0;
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            if (period == 0) begin
                sig_in = 1'b0;
                ph     = 0;
            end else begin
                ph++;
                if (ph >= period / 2) begin
                    sig_in = ~sig_in;
                    ph     = 0;
                end
            end
        end
    end

    typedef struct {
        int       per;
        bit       sel4;
        int       exp_freq;
        bit       exp_ovf;
        string    name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One start pulse, then observe up to 250 cycles of busy/valid on the chosen instance
    task automatic run_window(input bit sel4, input bit mid_start,
                              output logic [31:0] freq, output logic ovf,
                              output int nvalid, output int nbusy);
        bit b, v;
        nvalid = 0;
        nbusy  = 0;
        freq   = 32'hFFFF_FFFF;
        ovf    = 1'bx;
        @(negedge clk);
        if (sel4) start4 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start4 = 1'b0;
        for (int i = 0; i < 250; i++) begin
            b = sel4 ? busy4 : busy;
            v = sel4 ? freq_valid4 : freq_valid;
            if (b) nbusy++;
            if (v) begin
                nvalid++;
                freq = sel4 ? {28'd0, freq_out4} : freq_out;
                ovf  = sel4 ? overflow4 : overflow;
            end
            start = (mid_start && i == 50) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        vec_t        vecs[8];
        logic [31:0] f;
        logic        o;
        int          nv, nb, t;
        int          times[3];

        vecs[0] = '{0,  1'b0, 0,  1'b0, "stuck0"};
        vecs[1] = '{10, 1'b0, 10, 1'b0, "per10"};
        vecs[2] = '{2,  1'b0, 50, 1'b0, "per2"};
        vecs[3] = '{20, 1'b0, 5,  1'b0, "per20"};
        vecs[4] = '{4,  1'b1, 15, 1'b1, "w4_per4_sat"};
        vecs[5] = '{10, 1'b1, 10, 1'b0, "w4_per10"};
        vecs[6] = '{2,  1'b1, 15, 1'b1, "w4_per2_sat"};
        vecs[7] = '{4,  1'b0, 25, 1'b0, "per4"};

        rst    = 1'b1;
        start  = 1'b0;
        start4 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",     {31'd0, busy},       32'd0);
        check("rst_freq",     freq_out,            32'd0);
        check("rst_valid",    {31'd0, freq_valid}, 32'd0);
        check("rst_ovf",      {31'd0, overflow},   32'd0);
        check("rst_ovf4",     {31'd0, overflow4},  32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            period = vecs[k].per;
            repeat (30) @(negedge clk);
            run_window(vecs[k].sel4, 1'b0, f, o, nv, nb);
            check({vecs[k].name, "_freq"},   f,                 32'(vecs[k].exp_freq));
            check({vecs[k].name, "_ovf"},    {31'd0, o},        {31'd0, vecs[k].exp_ovf});
            check({vecs[k].name, "_nvalid"}, 32'(nv),           32'd1);
            check({vecs[k].name, "_nbusy"},  32'(nb),           32'd100);
        end

        // Result holds between windows
        repeat (20) @(negedge clk);
        check("hold_freq", freq_out, 32'd25);
        check("hold_freq4", {28'd0, freq_out4}, 32'd15);

        // Extra start mid-window must not extend or restart it
        period = 10;
        repeat (10) @(negedge clk);
        run_window(1'b0, 1'b1, f, o, nv, nb);
        check("midstart_nbusy",  32'(nb), 32'd100);
        check("midstart_nvalid", 32'(nv), 32'd1);
        check("midstart_freq",   f,       32'd10);

        // start held high: back-to-back windows 102 cycles apart
        nv = 0;
        @(negedge clk);
        start = 1'b1;
        for (t = 0; t < 500; t++) begin
            @(negedge clk);
            if (freq_valid) begin
                if (nv < 3) times[nv] = t;
                nv++;
                check("b2b_freq", freq_out, 32'd10);
            end
            if (nv == 2 && busy) start = 1'b0;
        end
        start = 1'b0;
        check("b2b_count", 32'(nv), 32'd3);
        if (nv >= 3) begin
            check("b2b_gap1", 32'(times[1] - times[0]), 32'd102);
            check("b2b_gap2", 32'(times[2] - times[1]), 32'd102);
        end

        // Reset 40 cycles into a window aborts it
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy",  {31'd0, busy},      32'd0);
        check("abort_freq",  freq_out,           32'd0);
        check("abort_ovf",   {31'd0, overflow},  32'd0);
        check("abort_ovf4",  {31'd0, overflow4}, 32'd0);
        rst = 1'b0;
        nv  = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (freq_valid) nv++;
        end
        check("abort_novalid", 32'(nv), 32'd0);
        run_window(1'b0, 1'b0, f, o, nv, nb);
        check("after_rst_nbusy",  32'(nb), 32'd100);
        check("after_rst_nvalid", 32'(nv), 32'd1);
        check("after_rst_freq",   f,       32'd10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
